// File: rtl/vgg_pkg.sv
// Shared definitions for the VGG16-lite input path: default geometry,
// the packer FSM state encoding and a counter-width helper.
package vgg_pkg;

  localparam int DEF_DWIDTH         = 32;
  localparam int DEF_NUM_CHANNEL_IN = 8;
  localparam int DEF_WIDTH          = 56;
  localparam int DEF_HEIGHT         = 56;
  localparam int FRAME_PIXELS       = DEF_WIDTH * DEF_HEIGHT;

  // Two-state packer FSM: gather channel beats, then hold the word for the FIFO.
  typedef enum logic {
    COLLECT = 1'b0,
    PUSH    = 1'b1
  } state_e;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vgg_input_packer.sv
// Serial-to-parallel channel packer feeding the VGG16-lite input FIFO.
// Gathers NUM_CHANNEL_ACTIVE channel words per pixel into lanes of one
// wide word, zero-pads the unused lanes, writes it to the FIFO and tracks
// frame boundaries so a misplaced s_last is flagged.
module vgg_input_packer
  import vgg_pkg::*;
#(
  parameter int DWIDTH             = DEF_DWIDTH,
  parameter int NUM_CHANNEL_IN     = DEF_NUM_CHANNEL_IN,
  parameter int NUM_CHANNEL_ACTIVE = 3,
  parameter int WIDTH              = DEF_WIDTH,
  parameter int HEIGHT             = DEF_HEIGHT
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [DWIDTH-1:0]                s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic                             s_last,
  output logic [NUM_CHANNEL_IN*DWIDTH-1:0] ff_wdata,
  output logic                             ff_wrreq,
  input  logic                             ff_full,
  output logic                             frame_done,
  output logic                             frame_err,
  output logic                             busy
);

  localparam int NUM_PIXELS = WIDTH * HEIGHT;
  localparam int CH_W       = cnt_width(NUM_CHANNEL_IN);
  localparam int PIX_W      = cnt_width(NUM_PIXELS);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNEL_ACTIVE - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [DWIDTH-1:0] lane_q [NUM_CHANNEL_IN];

  logic beat_acc;
  logic last_ch;
  logic pix_wrap;
  logic write_done;
  logic expected_last;

  // s_ready is a pure decode of the registered state so upstream never
  // sees a combinational path back from ff_full.
  assign s_ready       = (state_q == COLLECT);
  assign beat_acc      = s_valid && s_ready;
  assign last_ch       = (ch_cnt_q == CH_LAST);
  assign pix_wrap      = (pix_cnt_q == PIX_LAST);
  assign ff_wrreq      = (state_q == PUSH) && !ff_full;
  assign write_done    = ff_wrreq;
  assign expected_last = pix_wrap && last_ch;

  assign busy       = (state_q == PUSH) || (ch_cnt_q != '0);
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

  // Lane k sits at bits [(k+1)*DWIDTH-1 : k*DWIDTH] of the FIFO word.
  for (genvar gi = 0; gi < NUM_CHANNEL_IN; gi++) begin : g_flatten
    assign ff_wdata[gi*DWIDTH +: DWIDTH] = lane_q[gi];
  end

  // Next-state logic for the FSM, counters and frame status flags.
  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;

    case (state_q)
      COLLECT: begin
        if (beat_acc && last_ch) begin
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (write_done) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (beat_acc) begin
      ch_cnt_d = last_ch ? '0 : ch_cnt_q + CH_W'(1);
      // A misplaced s_last is only reported; the stream is not resynced.
      if (s_last != expected_last) begin
        frame_err_d = 1'b1;
      end
    end

    if (write_done) begin
      pix_cnt_d    = pix_wrap ? '0 : pix_cnt_q + PIX_W'(1);
      frame_done_d = pix_wrap;
    end
  end

  // Control registers; an asynchronous reset drops any partial or pending pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= COLLECT;
      ch_cnt_q     <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Lane file: write the accepted beat into lane ch_cnt and clear padding
  // lanes when the pixel completes, so the held word is always well defined.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_CHANNEL_IN; k++) begin
        lane_q[k] <= '0;
      end
    end else if (beat_acc) begin
      for (int k = 0; k < NUM_CHANNEL_IN; k++) begin
        if (k < NUM_CHANNEL_ACTIVE) begin
          if (ch_cnt_q == CH_W'(k)) begin
            lane_q[k] <= s_data;
          end
        end else if (last_ch) begin
          lane_q[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vgg_input_packer.sv
// Directed bench for vgg_input_packer on a 4x4 frame with 3 active channels.
module tb_vgg_input_packer;

  localparam int DW  = 32;
  localparam int NCI = 8;
  localparam int NCA = 3;
  localparam int WW  = 4;
  localparam int HH  = 4;
  localparam int NPIX = WW * HH;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic            s_last = 1'b0;
  logic [NCI*DW-1:0] ff_wdata;
  logic            ff_wrreq;
  logic            ff_full = 1'b0;
  logic            frame_done;
  logic            frame_err;
  logic            busy;

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  int          wr_count = 0;
  int          fd_count = 0;
  logic [NCI*DW-1:0] last_wdata = '0;
  int          wr_cyc[$];

  vgg_input_packer #(
    .DWIDTH(DW), .NUM_CHANNEL_IN(NCI), .NUM_CHANNEL_ACTIVE(NCA),
    .WIDTH(WW), .HEIGHT(HH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .ff_wdata(ff_wdata), .ff_wrreq(ff_wrreq), .ff_full(ff_full),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard of FIFO writes and frame_done pulses as seen at the clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resetn && ff_wrreq) begin
      wr_count   <= wr_count + 1;
      last_wdata <= ff_wdata;
      wr_cyc.push_back(cyc);
    end
    if (frame_done) fd_count <= fd_count + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [NCI*DW-1:0] act, input logic [NCI*DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [NCI*DW-1:0] pack3(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                                input logic [DW-1:0] c2);
    return {160'h0, c2, c1, c0};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    ff_full = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  // Send one pixel from a negedge; ff_full held high for 'stall' cycles once
  // the word is pending. Returns at the negedge after the FIFO write edge.
  task automatic send_pixel(input logic [DW-1:0] c0, input logic [DW-1:0] c1, input logic [DW-1:0] c2,
                            input logic last_flag, input int stall, input logic [NCI*DW-1:0] req);
    logic [DW-1:0] beats [3];
    beats[0] = c0; beats[1] = c1; beats[2] = c2;
    for (int ch = 0; ch < 3; ch++) begin
      s_valid = 1'b1;
      s_data  = beats[ch];
      s_last  = last_flag && (ch == 2);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    ff_full = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("stall_s_ready", {255'h0, s_ready}, '0);
      chk("stall_wrreq", {255'h0, ff_wrreq}, '0);
      chk("stall_wdata", ff_wdata, req);
      step();
    end
    ff_full = 1'b0;
    #1;
    chk("push_wrreq", {255'h0, ff_wrreq}, {255'h0, 1'b1});
    chk("push_s_ready", {255'h0, s_ready}, '0);
    chk("push_wdata", ff_wdata, req);
    step();
    chk("post_write_s_ready", {255'h0, s_ready}, {255'h0, 1'b1});
  endtask

  typedef struct {
    logic [DW-1:0]     c0, c1, c2;
    int                stall;
    logic [NCI*DW-1:0] exp_wdata;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int w0, f0, idx;
    logic rdy;
    logic [DW-1:0] words [12];

    vecs[0] = '{32'h11, 32'h22, 32'h33, 0,
                256'h0000000000000000000000000000000000000000000000330000002200000011};
    vecs[1] = '{32'hA1B2C3D4, 32'h0, 32'hFFFFFFFF, 10,
                256'h0000000000000000000000000000000000000000FFFFFFFF00000000A1B2C3D4};
    vecs[2] = '{32'h80000001, 32'h7FFFFFFE, 32'h5A5A5A5A, 1,
                256'h00000000000000000000000000000000000000005A5A5A5A7FFFFFFE80000001};
    vecs[3] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 2,
                256'h000000000000000000000000000000000000000012345678CAFEF00DDEADBEEF};

    // Reset state
    #1;
    chk("rst_s_ready", {255'h0, s_ready}, {255'h0, 1'b1});
    chk("rst_wrreq", {255'h0, ff_wrreq}, '0);
    chk("rst_wdata", ff_wdata, '0);
    chk("rst_frame_done", {255'h0, frame_done}, '0);
    chk("rst_frame_err", {255'h0, frame_err}, '0);
    chk("rst_busy", {255'h0, busy}, '0);
    do_reset();

    // Table-driven pixels, with and without back-pressure
    for (int v = 0; v < 4; v++) begin
      w0 = wr_count;
      send_pixel(vecs[v].c0, vecs[v].c1, vecs[v].c2, 1'b0, vecs[v].stall, vecs[v].exp_wdata);
      chk($sformatf("vec%0d_writes", v), 256'(wr_count), 256'(w0 + 1));
      chk($sformatf("vec%0d_data", v), last_wdata, vecs[v].exp_wdata);
      chk($sformatf("vec%0d_busy", v), {255'h0, busy}, '0);
    end
    chk("vec_frame_err", {255'h0, frame_err}, '0);

    // Full frame with correct s_last
    do_reset();
    w0 = wr_count;
    f0 = fd_count;
    for (int p = 0; p < NPIX; p++) begin
      send_pixel(32'h100*p + 1, 32'h100*p + 2, 32'h100*p + 3, (p == NPIX-1), 0,
                 pack3(32'h100*p + 1, 32'h100*p + 2, 32'h100*p + 3));
      if (p < NPIX-1) chk("frame_no_done_early", {255'h0, frame_done}, '0);
    end
    chk("frame_done_pulse", {255'h0, frame_done}, {255'h0, 1'b1});
    chk("frame_writes", 256'(wr_count), 256'(w0 + NPIX));
    step();
    chk("frame_done_single", {255'h0, frame_done}, '0);
    chk("frame_done_count", 256'(fd_count), 256'(f0 + 1));
    chk("frame_err_clean", {255'h0, frame_err}, '0);
    // Counter wrapped: a non-last pixel must not be flagged.
    send_pixel(32'h1, 32'h2, 32'h3, 1'b0, 0, pack3(32'h1, 32'h2, 32'h3));
    chk("wrap_frame_err", {255'h0, frame_err}, '0);

    // Misplaced s_last on pixel 5
    do_reset();
    w0 = wr_count;
    f0 = fd_count;
    for (int p = 0; p < NPIX; p++) begin
      send_pixel(32'h55000000 + p, 32'h66000000 + p, 32'h77000000 + p, (p == 4) || (p == NPIX-1), 0,
                 pack3(32'h55000000 + p, 32'h66000000 + p, 32'h77000000 + p));
      if (p < 4) chk("err_clear_before", {255'h0, frame_err}, '0);
      else       chk("err_held", {255'h0, frame_err}, {255'h0, 1'b1});
    end
    chk("err_done_pulse", {255'h0, frame_done}, {255'h0, 1'b1});
    chk("err_writes", 256'(wr_count), 256'(w0 + NPIX));
    step();
    chk("err_done_count", 256'(fd_count), 256'(f0 + 1));

    // Reset mid-pixel after two beats
    do_reset();
    w0 = wr_count;
    s_valid = 1'b1; s_data = 32'hBAD0; step();
    s_data = 32'hBAD1; step();
    s_valid = 1'b0;
    chk("mid_busy", {255'h0, busy}, {255'h0, 1'b1});
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", {255'h0, busy}, '0);
    chk("mid_rst_wdata", ff_wdata, '0);
    chk("mid_rst_s_ready", {255'h0, s_ready}, {255'h0, 1'b1});
    chk("mid_rst_wrreq", {255'h0, ff_wrreq}, '0);
    step();
    resetn = 1'b1;
    send_pixel(32'hA, 32'hB, 32'hC, 1'b0, 0, pack3(32'hA, 32'hB, 32'hC));
    chk("mid_writes", 256'(wr_count), 256'(w0 + 1));
    chk("mid_data", last_wdata, pack3(32'hA, 32'hB, 32'hC));

    // Reset while a stalled word is pending
    w0 = wr_count;
    s_valid = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      s_data = 32'hE0 + ch;
      step();
    end
    s_valid = 1'b0;
    ff_full = 1'b1;
    step();
    resetn = 1'b0;
    ff_full = 1'b0;
    #1;
    chk("push_rst_wrreq", {255'h0, ff_wrreq}, '0);
    chk("push_rst_s_ready", {255'h0, s_ready}, {255'h0, 1'b1});
    step();
    resetn = 1'b1;
    step();
    chk("push_rst_writes", 256'(wr_count), 256'(w0));

    // Continuous s_valid over four pixels
    do_reset();
    for (int i = 0; i < 12; i++) words[i] = 32'h1000 + i;
    wr_cyc.delete();
    w0 = wr_count;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      s_valid = (idx < 12);
      s_data  = (idx < 12) ? words[idx] : '0;
      #1;
      rdy = s_ready;
      chk($sformatf("cont_s_ready_c%0d", c), {255'h0, s_ready}, {255'h0, ((c % 4) != 3)});
      step();
      if (rdy && idx < 12) idx++;
    end
    s_valid = 1'b0;
    step();
    chk("cont_writes", 256'(wr_count), 256'(w0 + 4));
    chk("cont_last_data", last_wdata, pack3(32'h1009, 32'h100A, 32'h100B));
    if (wr_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk($sformatf("cont_spacing_%0d", i), 256'(wr_cyc[i] - wr_cyc[i-1]), 256'(4));
    end else begin
      chk("cont_wr_queue", 256'(wr_cyc.size()), 256'(4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vgg_input_packer.md
# vgg_input_packer

Upstream feeder for the VGG16-lite core. Accepts a serial 32-bit stream of per-pixel channel words over a valid/ready handshake and assembles them into one `NUM_CHANNEL_IN*DWIDTH`-bit word per pixel. Channels beyond `NUM_CHANNEL_ACTIVE` are zero-padded, so RGB input fills the 8-lane core input. Each word is pushed into the core's input FIFO, and the block tracks frame boundaries against `WIDTH*HEIGHT`.

## Interface
Parameters:
- `DWIDTH`, 32, width of one channel word
- `NUM_CHANNEL_IN`, 8, lanes per FIFO word
- `NUM_CHANNEL_ACTIVE`, 3, channels actually supplied per pixel (1..`NUM_CHANNEL_IN`)
- `WIDTH`, 56, pixels per row
- `HEIGHT`, 56, rows per frame

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous, active-low reset
- `s_data`  in  `DWIDTH`  channel word, channel 0 first
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  block accepts `s_data`
- `s_last`  in  1  marks the last beat of a frame
- `ff_wdata`  out  `NUM_CHANNEL_IN*DWIDTH`  packed pixel word; lane k at bits `[(k+1)*DWIDTH-1 : k*DWIDTH]`
- `ff_wrreq`  out  1  FIFO write strobe
- `ff_full`  in  1  FIFO full
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is written
- `frame_err`  out  1  sticky `s_last` mismatch flag
- `busy`  out  1  a pixel is partially collected or pending write

## Operation
- FSM with two states:
  - COLLECT: `s_ready`=1.
  - PUSH: `s_ready`=0, word held.
- Beat accepted when `s_valid && s_ready`; it is written into lane `ch_cnt`, then `ch_cnt++`.
- On the beat accepted with `ch_cnt == NUM_CHANNEL_ACTIVE-1`:
  - `ch_cnt` returns to 0 and FSM goes to PUSH.
  - Lanes `NUM_CHANNEL_ACTIVE..NUM_CHANNEL_IN-1` are forced to 0.
- In PUSH, `ff_wrreq = !ff_full` (combinational from registered state).
  - A write completes in any PUSH cycle with `ff_full`=0; the FSM then returns to COLLECT next cycle.
  - `ff_full`=1 holds PUSH indefinitely; `ff_wdata` stays stable.
- Pixel counter `pix_cnt`, width `$clog2(WIDTH*HEIGHT)`, increments on each completed write.
  - At `WIDTH*HEIGHT-1` it wraps to 0 and `frame_done` pulses in the following cycle.
- `s_last` check:
  - On each accepted beat, `expected_last = (pix_cnt == WIDTH*HEIGHT-1) && (ch_cnt == NUM_CHANNEL_ACTIVE-1)`.
  - `s_last != expected_last` sets `frame_err`=1, which stays set until reset.
  - Data flow and counters are unaffected; no resync.
- `busy = (state==PUSH) || (ch_cnt != 0)`.
- `s_data` is stored unmodified; no arithmetic is applied.

## Timing
- Reset values:
  - `s_ready`=1 (FSM in COLLECT)
  - `ff_wrreq`=0, `ff_wdata`=0
  - `frame_done`=0, `frame_err`=0, `busy`=0
  - all counters 0
- Latency: last channel beat accepted at cycle N → `ff_wrreq`=1 at cycle N+1 when `ff_full`=0.
- Throughput: one pixel per `NUM_CHANNEL_ACTIVE`+1 cycles when unstalled.
- `s_ready` is a registered state decode; upstream may hold `s_valid` high across `s_ready`=0 without losing data.
- `ff_full` sampled in the same cycle as `ff_wrreq`; the FIFO write is accepted at that clock edge.
- `ff_full` rising while in PUSH: `ff_wrreq` deasserts in the same cycle and no write occurs.
- `frame_done` and the wrapped `pix_cnt`=0 are both visible at cycle N+2 relative to the last beat (unstalled).
- `resetn` asserted mid-pixel or mid-PUSH:
  - The partial or pending word is discarded; nothing is written.
  - All outputs return to their reset values immediately (asynchronous reset).
- `NUM_CHANNEL_ACTIVE == NUM_CHANNEL_IN`: no padding lanes exist.

## Structure
- Shared package `vgg_pkg` holds:
  - `DWIDTH`=32 and `NUM_CHANNEL_IN`=8 defaults
  - `localparam FRAME_PIXELS = WIDTH*HEIGHT`
  - the FSM state enum {COLLECT, PUSH}
- Single module, no sub-modules. The lane register file is a `NUM_CHANNEL_IN`-entry array indexed by `ch_cnt` and flattened onto `ff_wdata`.

## Test plan
- Single pixel, `NUM_CHANNEL_ACTIVE`=3, beats 0x11, 0x22, 0x33, `ff_full`=0 → one `ff_wrreq` pulse one cycle after the 0x33 beat; `ff_wdata` = five zero lanes above 0x33, 0x22, 0x11 (lane 0 = 0x11 in the LSBs).
- Back-pressure: `ff_full`=1 for 10 cycles after the pixel completes → `s_ready`=0, `ff_wrreq`=0 and `ff_wdata` stable throughout; exactly one write on the first cycle with `ff_full`=0.
- Full frame, `WIDTH`=`HEIGHT`=4, 16 pixels with correct `s_last` → 16 writes, one `frame_done` pulse after write 16, `pix_cnt` back to 0, `frame_err`=0.
- Wrong `s_last`: asserted on pixel 5 of a 16-pixel frame → `frame_err`=1 the next cycle and held; writes continue and `frame_done` still fires after pixel 16.
- Reset mid-pixel: assert `resetn`=0 after 2 of 3 beats, release, then send a full pixel 0xA, 0xB, 0xC → exactly one write with lanes 0..2 = 0xA, 0xB, 0xC; no stale data.
- Continuous `s_valid`=1 over 4 pixels, `ff_full`=0 → writes 4 cycles apart; `s_ready` low exactly one cycle per pixel.
